// File: rtl/mul_signmag_pipe_pkg.sv
// Shared constants, stage payload types and magnitude helpers for the sign-magnitude
// multiplier front end and its downstream complement stage.
package mul_signmag_pipe_pkg;

   localparam logic WIDTH_32 = 1'b0;
   localparam logic WIDTH_16 = 1'b1;
   localparam int   STAGES   = 3;

   typedef struct packed {
      logic        valid;
      logic        width;
      logic [15:0] mag_a;
      logic [15:0] mag_b;
      logic        sgn_hi;
      logic        sgn_lo;
   } s1_t;

   typedef struct packed {
      logic        valid;
      logic        width;
      logic        sgn_hi;
      logic        sgn_lo;
      logic [15:0] hh;
      logic [15:0] hl;
      logic [15:0] lh;
      logic [15:0] ll;
   } s2_t;

   // Unsigned result width equals operand width, so the most negative value maps onto
   // its own bit pattern (0x8000 / 0x80), which is exactly the required magnitude.
   function automatic logic [15:0] abs16(input logic [15:0] x);
      return x[15] ? (~x + 16'd1) : x;
   endfunction

   function automatic logic [7:0] abs8(input logic [7:0] x);
      return x[7] ? (~x + 8'd1) : x;
   endfunction

endpackage

// File: rtl/mul_signmag_pipe_mul8x8u.sv
// Combinational unsigned 8x8 -> 16-bit multiplier used for the partial products.
module mul8x8u (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   logic [15:0] a_ext;
   logic [15:0] b_ext;

   assign a_ext = {8'd0, a};
   assign b_ext = {8'd0, b};
   assign p     = a_ext * b_ext;

endmodule

// File: rtl/mul_signmag_pipe.sv
// Three-stage sign-magnitude multiplier: 16x16 or dual 8x8 lanes, valid/ready with
// whole-pipe stall, per-lane result signs with zero-product sign suppression.
module mul_signmag_pipe
   import mul_signmag_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        width,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] prod,
   output logic [1:0]  sign,
   output logic        width_o
);

   logic en;

   s1_t s1_d;
   s1_t s1_q;
   s2_t s2_d;
   s2_t s2_q;

   logic [15:0] pp_hh;
   logic [15:0] pp_hl;
   logic [15:0] pp_lh;
   logic [15:0] pp_ll;

   logic [16:0] cross_sum;
   logic [31:0] full_prod;
   logic [31:0] prod_d;
   logic [1:0]  sign_d;

   // The output register is the only place a slot can be blocked, so it gates everything.
   assign en       = out_ready | ~out_valid;
   assign in_ready = en;

   always_comb begin
      s1_d        = '0;
      s1_d.valid  = in_valid;
      s1_d.width  = width;
      s1_d.sgn_hi = a[15] ^ b[15];
      if (width == WIDTH_16) begin
         s1_d.mag_a  = {abs8(a[15:8]), abs8(a[7:0])};
         s1_d.mag_b  = {abs8(b[15:8]), abs8(b[7:0])};
         s1_d.sgn_lo = a[7] ^ b[7];
      end else begin
         s1_d.mag_a  = abs16(a);
         s1_d.mag_b  = abs16(b);
         s1_d.sgn_lo = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
      end else if (en) begin
         s1_q <= s1_d;
      end
   end

   mul8x8u u_mul_hh (.a(s1_q.mag_a[15:8]), .b(s1_q.mag_b[15:8]), .p(pp_hh));
   mul8x8u u_mul_hl (.a(s1_q.mag_a[15:8]), .b(s1_q.mag_b[7:0]),  .p(pp_hl));
   mul8x8u u_mul_lh (.a(s1_q.mag_a[7:0]),  .b(s1_q.mag_b[15:8]), .p(pp_lh));
   mul8x8u u_mul_ll (.a(s1_q.mag_a[7:0]),  .b(s1_q.mag_b[7:0]),  .p(pp_ll));

   always_comb begin
      s2_d        = '0;
      s2_d.valid  = s1_q.valid;
      s2_d.width  = s1_q.width;
      s2_d.sgn_hi = s1_q.sgn_hi;
      s2_d.sgn_lo = s1_q.sgn_lo;
      s2_d.hh     = pp_hh;
      s2_d.hl     = pp_hl;
      s2_d.lh     = pp_lh;
      s2_d.ll     = pp_ll;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_q <= '0;
      end else if (en) begin
         s2_q <= s2_d;
      end
   end

   assign cross_sum = {1'b0, s2_q.hl} + {1'b0, s2_q.lh};
   assign full_prod = {s2_q.hh, 16'd0} + {7'd0, cross_sum, 8'd0} + {16'd0, s2_q.ll};

   // A zero magnitude always reports a positive sign so the complement stage never sees -0.
   always_comb begin
      prod_d = '0;
      sign_d = '0;
      if (s2_q.width == WIDTH_16) begin
         prod_d = {s2_q.hh, s2_q.ll};
         sign_d = {s2_q.sgn_hi & (|s2_q.hh), s2_q.sgn_lo & (|s2_q.ll)};
      end else begin
         prod_d = full_prod;
         sign_d = {s2_q.sgn_hi & (|full_prod), 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         prod      <= '0;
         sign      <= '0;
         width_o   <= 1'b0;
      end else if (en) begin
         out_valid <= s2_q.valid;
         prod      <= prod_d;
         sign      <= sign_d;
         width_o   <= s2_q.width;
      end
   end

endmodule

// File: tb/tb_mul_signmag_pipe.sv
// Self-checking bench for mul_signmag_pipe: directed vectors, streaming, stall and reset.
module tb_mul_signmag_pipe;

   logic        clk;
   logic        rst;
   logic        width;
   logic [15:0] a;
   logic [15:0] b;
   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] prod;
   logic [1:0]  sign;
   logic        width_o;

   int          checks;
   int          errors;
   logic [34:0] exp_q[$];

   mul_signmag_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .width    (width),
      .a        (a),
      .b        (b),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .prod     (prod),
      .sign     (sign),
      .width_o  (width_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Signed reference: {width, sign[1:0], magnitude[31:0]}
   function automatic logic [34:0] ref_model(input logic w, input logic [15:0] xa, input logic [15:0] xb);
      logic signed [31:0] p;
      logic signed [15:0] ph;
      logic signed [15:0] pl;
      logic [15:0]        mh;
      logic [15:0]        ml;
      logic [31:0]        mag;
      logic [1:0]         s;
      if (!w) begin
         p   = $signed(xa) * $signed(xb);
         s   = {(p < 0), 1'b0};
         mag = (p < 0) ? -p : p;
      end else begin
         ph  = $signed(xa[15:8]) * $signed(xb[15:8]);
         pl  = $signed(xa[7:0]) * $signed(xb[7:0]);
         mh  = (ph < 0) ? -ph : ph;
         ml  = (pl < 0) ? -pl : pl;
         s   = {(ph < 0), (pl < 0)};
         mag = {mh, ml};
      end
      return {w, s, mag};
   endfunction

   // Drive one item with out_ready high; returns at the sample point 3 edges later.
   task automatic run_one(input logic w, input logic [15:0] xa, input logic [15:0] xb, output logic early);
      @(negedge clk);
      width = w; a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      early = out_valid;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
      checks++;
      if (prod !== 32'd0 || sign !== 2'b00 || width_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_payload: prod=%h sign=%b width_o=%b, want 0", prod, sign, width_o);
      end
   endtask

   task automatic test_mode0();
      logic early;
      run_one(1'b0, 16'h0003, 16'hFFFE, early);
      checks++;
      if (early !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mode0_latency: early=%b out_valid=%b, want 0/1", early, out_valid);
      end
      checks++;
      if (prod !== 32'h0000_0006 || sign !== 2'b10 || width_o !== 1'b0) begin
         errors++;
         $display("FAIL mode0_basic: prod=%h sign=%b w=%b, want 00000006/10/0", prod, sign, width_o);
      end
   endtask

   task automatic test_mode0_extreme();
      logic early;
      run_one(1'b0, 16'h8000, 16'h8000, early);
      checks++;
      if (out_valid !== 1'b1 || prod !== 32'h4000_0000 || sign !== 2'b00) begin
         errors++;
         $display("FAIL mode0_minmin: v=%b prod=%h sign=%b, want 1/40000000/00", out_valid, prod, sign);
      end
      run_one(1'b0, 16'h8000, 16'h7FFF, early);
      checks++;
      if (out_valid !== 1'b1 || prod !== 32'h3FFF_8000 || sign !== 2'b10) begin
         errors++;
         $display("FAIL mode0_minmax: v=%b prod=%h sign=%b, want 1/3fff8000/10", out_valid, prod, sign);
      end
   endtask

   task automatic test_mode1();
      logic early;
      run_one(1'b1, 16'h8005, 16'hFFFD, early);
      checks++;
      if (out_valid !== 1'b1 || prod !== 32'h0080_000F || sign !== 2'b01 || width_o !== 1'b1) begin
         errors++;
         $display("FAIL mode1_lanes: v=%b prod=%h sign=%b w=%b, want 1/0080000f/01/1",
                  out_valid, prod, sign, width_o);
      end
   endtask

   task automatic test_zero_rule();
      logic early;
      run_one(1'b1, 16'h00F0, 16'h8500, early);
      checks++;
      if (out_valid !== 1'b1 || prod !== 32'd0 || sign !== 2'b00) begin
         errors++;
         $display("FAIL zero_mode1: v=%b prod=%h sign=%b, want 1/00000000/00", out_valid, prod, sign);
      end
      run_one(1'b0, 16'h0000, 16'hFFFF, early);
      checks++;
      if (out_valid !== 1'b1 || prod !== 32'd0 || sign !== 2'b00) begin
         errors++;
         $display("FAIL zero_mode0: v=%b prod=%h sign=%b, want 1/00000000/00", out_valid, prod, sign);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va[8];
      logic [15:0] vb[8];
      logic [34:0] e;
      int sent;
      int got;
      int cyc;
      va = '{16'h0003, 16'h8005, 16'h8000, 16'h7F81, 16'hFFFF, 16'h0000, 16'h1234, 16'h80FF};
      vb = '{16'hFFFE, 16'hFFFD, 16'h7FFF, 16'h8080, 16'hFFFF, 16'h5555, 16'hFEDC, 16'h7F01};
      sent = 0; got = 0; cyc = 0;
      exp_q.delete();
      while (got < 8 && cyc < 40) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = (sent < 8);
         width     = sent[0];
         a         = va[sent % 8];
         b         = vb[sent % 8];
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(width, a, b));
            sent++;
         end
         if (out_valid && out_ready) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            if ({width_o, sign, prod} !== e) begin
               errors++;
               $display("FAIL b2b_item%0d: got %h want %h", got, {width_o, sign, prod}, e);
            end
            got++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 8 || cyc !== 11) begin
         errors++;
         $display("FAIL b2b_throughput: items=%0d cycles=%0d, want 8/11", got, cyc);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] va[6];
      logic [15:0] vb[6];
      logic [34:0] e;
      logic        wm;
      int sent;
      int got;
      int cyc;
      va = '{16'h8000, 16'h0102, 16'hFF7F, 16'h4000, 16'h8181, 16'h00FF};
      vb = '{16'h0002, 16'hFEFD, 16'h8080, 16'hC000, 16'h7F7F, 16'hFF00};
      sent = 0; got = 0; cyc = 0;
      wm = 1'($urandom_range(0, 1));
      exp_q.delete();
      while (got < 6 && cyc < 40) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc <= 7);
         in_valid  = (sent < 6);
         width     = wm;
         a         = va[sent % 6];
         b         = vb[sent % 6];
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("FAIL bp_in_ready_c%0d: got %b want %b", cyc, in_ready, !(out_valid && !out_ready));
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(width, a, b));
            sent++;
            wm = 1'($urandom_range(0, 1));
         end
         if (out_valid && out_ready) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            if ({width_o, sign, prod} !== e) begin
               errors++;
               $display("FAIL bp_item%0d: got %h want %h", got, {width_o, sign, prod}, e);
            end
            got++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 6 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL bp_count: items=%0d left=%0d, want 6/0", got, exp_q.size());
      end
   endtask

   task automatic test_async_reset();
      logic [34:0] e;
      int sent;
      int got;
      int cyc;
      sent = 0; got = 0;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         out_ready = 1'b1; in_valid = 1'b1; width = 1'(i % 2);
         a = 16'h1111 * 16'(i + 1); b = 16'hF00D;
         #1;
         if (in_valid && in_ready) exp_q.push_back(ref_model(width, a, b));
         if (out_valid && out_ready) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            if ({width_o, sign, prod} !== e) begin
               errors++;
               $display("FAIL rst_pre_item: got %h want %h", {width_o, sign, prod}, e);
            end
         end
      end
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || prod !== 32'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: out_valid=%b prod=%h in_ready=%b, want 0/0/1", out_valid, prod, in_ready);
      end
      exp_q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      while (cyc < 16) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = (sent < 4);
         width     = 1'b0;
         a         = 16'hA000 + 16'(sent);
         b         = 16'h0007;
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(width, a, b));
            sent++;
         end
         if (out_valid && out_ready) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            if ({width_o, sign, prod} !== e) begin
               errors++;
               $display("FAIL rst_post_item%0d: got %h want %h", got, {width_o, sign, prod}, e);
            end
            got++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 4) begin
         errors++;
         $display("FAIL rst_post_count: items=%0d, want 4", got);
      end
   endtask

   function automatic logic [15:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 16'h8000;
         1:       return 16'h0000;
         2:       return 16'h7FFF;
         3:       return 16'h8080;
         default: return 16'($urandom());
      endcase
   endfunction

   task automatic test_random();
      logic [34:0] e;
      logic        pend;
      logic        cw;
      logic [15:0] ca;
      logic [15:0] cb;
      int got;
      int bad;
      pend = 1'b0; cw = 1'b0; ca = '0; cb = '0;
      got = 0; bad = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 10000 + 12; cyc++) begin
         @(negedge clk);
         if (!pend && cyc < 10000 && $urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            cw   = 1'($urandom_range(0, 1));
            ca   = pick_operand();
            cb   = pick_operand();
         end
         in_valid  = pend;
         width     = cw;
         a         = ca;
         b         = cb;
         out_ready = (cyc >= 10000) || ($urandom_range(0, 3) != 0);
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(width, a, b));
            pend = 1'b0;
         end
         if (out_valid && out_ready) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'h7_FFFF_FFFF;
            if ({width_o, sign, prod} !== e) begin
               errors++;
               bad++;
               if (bad <= 10) $display("FAIL rand_item%0d: got %h want %h", got, {width_o, sign, prod}, e);
            end
            got++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (exp_q.size() !== 0 || got < 1000) begin
         errors++;
         $display("FAIL rand_drain: left=%0d items=%0d, want 0 left and >=1000 items", exp_q.size(), got);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      width     = 1'b0;
      a         = '0;
      b         = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #3;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_mode0();
      test_mode0_extreme();
      test_mode1();
      test_zero_rule();
      test_back_to_back();
      test_backpressure();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
